// File: rtl/cpu_pkg.sv
// Shared types and Hack ISA field positions for the CPU control sequencer.
package cpu_pkg;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned WORD_W  = 16;

    localparam int unsigned OPC     = 15;
    localparam int unsigned DEST_A  = 5;
    localparam int unsigned DEST_D  = 4;
    localparam int unsigned DEST_M  = 3;
    localparam int unsigned JMP_LSB = 0;

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MWRITE,
        UPDATE,
        HALT
    } state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// ROM / RAM / datapath signals seen by the sequencer (master) and its environment (slave).
interface cpu_sequencer_if;
    import cpu_pkg::*;

    logic              rom_req;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_valid;
    logic [WORD_W-1:0] rom_data;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] a_val;
    logic              zr;
    logic              ng;
    logic              a_load;
    logic              d_load;
    logic              ram_we;
    logic              ram_ready;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    modport master (
        output rom_req, rom_addr, instr, a_load, d_load, ram_we, pc, halted,
        input  rom_valid, rom_data, a_val, zr, ng, ram_ready
    );

    modport slave (
        input  rom_req, rom_addr, instr, a_load, d_load, ram_we, pc, halted,
        output rom_valid, rom_data, a_val, zr, ng, ram_ready
    );

endinterface

// File: rtl/jump_cond.sv
// Hack jump-condition decode: j1j2j3 against the ALU zero/negative flags.
module jump_cond (
    input  logic       opcode,
    input  logic [2:0] j,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        if (opcode) begin
            unique case (j)
                3'b000:  take = 1'b0;
                3'b001:  take = !ng && !zr;
                3'b010:  take = zr;
                3'b011:  take = !ng;
                3'b100:  take = ng;
                3'b101:  take = !zr;
                3'b110:  take = zr || ng;
                3'b111:  take = 1'b1;
                default: take = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle Hack control sequencer: fetch, execute strobes, optional M write, PC update.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cpu_sequencer_if.master   bus
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [WORD_W-1:0] instr_q;
    logic              take_q;
    logic [ADDR_W-1:0] tgt_q;
    logic              halted_q;
    logic              take_d;
    logic              unused_a_msb;

    assign unused_a_msb = bus.a_val[WORD_W-1];

    jump_cond u_jump_cond (
        .opcode (instr_q[OPC]),
        .j      (instr_q[JMP_LSB +: 3]),
        .zr     (bus.zr),
        .ng     (bus.ng),
        .take   (take_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            take_q   <= 1'b0;
            tgt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.rom_valid) begin
                        instr_q <= bus.rom_data;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // jump_cond already yields 0 for A-instructions
                    take_q <= take_d;
                    if (instr_q[OPC]) begin
                        tgt_q   <= bus.a_val[ADDR_W-1:0];
                        state_q <= instr_q[DEST_M] ? MWRITE : UPDATE;
                    end else begin
                        state_q <= UPDATE;
                    end
                end
                MWRITE: begin
                    if (bus.ram_ready) begin
                        state_q <= UPDATE;
                    end
                end
                UPDATE: begin
                    pc_q <= take_q ? tgt_q : pc_q + PC_ONE;
                    // unconditional jump onto the previous word is the (END) self-loop
                    if (take_q && (instr_q[JMP_LSB +: 3] == 3'b111) && (tgt_q == pc_q - PC_ONE)) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    assign bus.rom_req  = (state_q == FETCH);
    assign bus.rom_addr = pc_q;
    assign bus.instr    = instr_q;
    assign bus.a_load   = (state_q == EXEC) && (!instr_q[OPC] || instr_q[DEST_A]);
    assign bus.d_load   = (state_q == EXEC) && instr_q[OPC] && instr_q[DEST_D];
    assign bus.ram_we   = (state_q == MWRITE);
    assign bus.pc       = pc_q;
    assign bus.halted   = halted_q;

endmodule
